// File: rtl/proc_pkg.sv
// Shared constants, state encodings and byte-selection helper for the result dump.
package proc_pkg;

  localparam int unsigned NUM_REGS         = 16;
  localparam int unsigned REG_W            = 12;
  localparam int unsigned BYTES_PER_REG    = 2;
  localparam int unsigned NUM_BYTES        = NUM_REGS * BYTES_PER_REG;
  localparam int unsigned BYTE_IDX_W       = $clog2(NUM_BYTES);
  localparam int unsigned SHADOW_W         = NUM_REGS * REG_W;
  localparam int unsigned DEF_CLKS_PER_BIT = 434;

  // Serializer bit-level states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } ser_state_e;

  // Frame sequencer states
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND,
    SEQ_DONE
  } seq_state_e;

  // Even bytes carry rk[7:0], odd bytes carry rk[11:8] zero-extended.
  function automatic logic [7:0] result_byte(input logic [SHADOW_W-1:0] sh,
                                             input logic [BYTE_IDX_W-1:0] idx);
    logic [REG_W-1:0] r;
    r = sh[int'(idx[BYTE_IDX_W-1:1]) * REG_W +: REG_W];
    return idx[0] ? 8'(r[REG_W-1:8]) : r[7:0];
  endfunction

endpackage

// File: rtl/result_uart_dump_if.sv
// Result-register and UART status bundle between the core side and the dumper.
interface result_uart_dump_if;
  import proc_pkg::*;

  logic             end_process;
  logic [REG_W-1:0] r1, r2, r3, r4, r5, r6, r7, r8;
  logic [REG_W-1:0] r9, r10, r11, r12, r13, r14, r15, r16;
  logic             tx;
  logic             busy;
  logic             done;

  modport master (
    output end_process,
    output r1, r2, r3, r4, r5, r6, r7, r8,
    output r9, r10, r11, r12, r13, r14, r15, r16,
    input  tx, busy, done
  );

  modport slave (
    input  end_process,
    input  r1, r2, r3, r4, r5, r6, r7, r8,
    input  r9, r10, r11, r12, r13, r14, r15, r16,
    output tx, busy, done
  );

endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer; accepts a new byte in the last stop-bit cycle so bytes run back-to-back.
module uart_byte_tx
  import proc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready_c,
  output logic       tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  ser_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       sh, sh_d;
  logic             tx_d;
  logic             baud_end;

  assign baud_end = (cnt == CNT_LAST);

  // State and registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      sh      <= sh_d;
      tx      <= tx_d;
    end
  end

  // Bit timing, shifting and acceptance of the next byte
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    sh_d      = sh;
    tx_d      = tx;
    ready_c   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        tx_d    = 1'b1;
      end
      ST_START: begin
        if (baud_end) begin
          state_d   = ST_DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = sh[0];
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
            sh_d      = {1'b0, sh[7:1]};
            tx_d      = sh[1];
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          ready_c = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ready_c && valid) begin
      state_d = ST_START;
      cnt_d   = '0;
      sh_d    = data;
      tx_d    = 1'b0;
    end
  end

endmodule

// File: rtl/result_uart_dump.sv
// Snapshots the sixteen result registers on end_process rising and streams them as 32 UART bytes.
module result_uart_dump
  import proc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input logic               clk,
  input logic               rst,
  result_uart_dump_if.slave bus
);

  seq_state_e            state, state_d;
  logic [BYTE_IDX_W-1:0] byte_idx, byte_idx_d;
  logic [SHADOW_W-1:0]   shadow;
  logic                  ep_q;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  trigger_c;
  logic                  capture_c;
  logic                  valid_c;
  logic [7:0]            data_c;
  logic                  ser_ready_c;
  logic                  ser_tx;

  assign trigger_c = bus.end_process & ~ep_q;

  // Sequencer state, snapshot and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEQ_IDLE;
      byte_idx <= '0;
      shadow   <= '0;
      ep_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      byte_idx <= byte_idx_d;
      ep_q     <= bus.end_process;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (capture_c) begin
        shadow <= {bus.r16, bus.r15, bus.r14, bus.r13, bus.r12, bus.r11, bus.r10, bus.r9,
                   bus.r8,  bus.r7,  bus.r6,  bus.r5,  bus.r4,  bus.r3,  bus.r2,  bus.r1};
      end
    end
  end

  // Byte sequencing; the first byte comes straight from r1 since the shadow loads on the same edge
  always_comb begin
    state_d    = state;
    byte_idx_d = byte_idx;
    busy_d     = busy_q;
    done_d     = 1'b0;
    capture_c  = 1'b0;
    valid_c    = 1'b0;
    data_c     = result_byte(shadow, BYTE_IDX_W'(byte_idx + 1'b1));

    case (state)
      SEQ_IDLE: begin
        if (trigger_c) begin
          capture_c  = 1'b1;
          valid_c    = 1'b1;
          data_c     = bus.r1[7:0];
          byte_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = SEQ_SEND;
        end
      end
      SEQ_SEND: begin
        if (ser_ready_c) begin
          if (byte_idx == BYTE_IDX_W'(NUM_BYTES - 1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = SEQ_DONE;
          end else begin
            valid_c    = 1'b1;
            byte_idx_d = byte_idx + 1'b1;
          end
        end
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid_c),
    .data   (data_c),
    .ready_c(ser_ready_c),
    .tx     (ser_tx)
  );

  assign bus.tx   = ser_tx;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_result_uart_dump.sv
// Randomized checks of the result dump against a frame-level bit-stream model.
module tb_result_uart_dump;

  localparam int CPB     = 4;
  localparam int BYTE_T  = 10 * CPB;
  localparam int FRAME_T = 32 * BYTE_T;
  localparam int RST_CYC = 5 * BYTE_T + 3 * CPB + 1;

  localparam int M_PLAIN  = 0;
  localparam int M_SNAP   = 1;
  localparam int M_RETRIG = 2;
  localparam int M_HOLD   = 3;
  localparam int M_RST    = 4;

  logic clk = 1'b0;
  logic rst;
  logic [11:0] exp_regs [16];
  int vectors = 0;
  int miscompares = 0;

  result_uart_dump_if bus ();

  result_uart_dump #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Frame content model: byte 2k is rk[7:0], byte 2k+1 is rk[11:8]
  function automatic int exp_byte(input int b);
    int v;
    v = int'(exp_regs[b / 2]);
    return (b % 2 == 0) ? (v & 255) : ((v >> 8) & 15);
  endfunction

  // Line level for cycle c of the frame: start 0, 8 data LSB first, stop 1
  function automatic int exp_bit(input int c);
    int s;
    s = (c % BYTE_T) / CPB;
    if (s == 0) return 0;
    if (s == 9) return 1;
    return (exp_byte(c / BYTE_T) >> (s - 1)) & 1;
  endfunction

  task automatic set_regs();
    bus.r1  = exp_regs[0];  bus.r2  = exp_regs[1];  bus.r3  = exp_regs[2];  bus.r4  = exp_regs[3];
    bus.r5  = exp_regs[4];  bus.r6  = exp_regs[5];  bus.r7  = exp_regs[6];  bus.r8  = exp_regs[7];
    bus.r9  = exp_regs[8];  bus.r10 = exp_regs[9];  bus.r11 = exp_regs[10]; bus.r12 = exp_regs[11];
    bus.r13 = exp_regs[12]; bus.r14 = exp_regs[13]; bus.r15 = exp_regs[14]; bus.r16 = exp_regs[15];
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 16; i++) exp_regs[i] = 12'($urandom);
  endtask

  // Check idle, then raise end_process at a negedge
  task automatic start_frame();
    chk("idle_tx", 32'(bus.tx), 1);
    chk("idle_busy", 32'(bus.busy), 0);
    bus.end_process = 1'b1;
  endtask

  // Follow one frame cycle by cycle; trigger edge is the posedge after the caller's negedge
  task automatic run_frame(input int mode);
    logic [7:0] rx;
    int busy_hits;
    rx = '0;
    for (int c = 0; c < FRAME_T; c++) begin
      int slot;
      @(negedge clk);
      chk("tx", 32'(bus.tx), 32'(exp_bit(c)));
      chk("busy", 32'(bus.busy), 1);
      chk("done_low", 32'(bus.done), 0);
      slot = c % BYTE_T;
      if ((slot % CPB == 2) && (slot / CPB >= 1) && (slot / CPB <= 8)) rx = {bus.tx, rx[7:1]};
      if (slot == 9 * CPB + 2) chk($sformatf("byte%0d", c / BYTE_T), 32'(rx), 32'(exp_byte(c / BYTE_T)));
      case (mode)
        M_PLAIN:  if (c == 1) bus.end_process = 1'b0;
        M_SNAP: begin
          if (c == 0) bus.r1 = 12'hFFF;
          if (c == 1) bus.end_process = 1'b0;
        end
        M_RETRIG: begin
          if (c == 1) bus.end_process = 1'b0;
          if (c == 10 * BYTE_T + 5) bus.end_process = 1'b1;
          if (c == 10 * BYTE_T + 7) bus.end_process = 1'b0;
        end
        M_RST: begin
          if (c == RST_CYC) begin
            rst = 1'b1;
            #1;
            chk("rst_tx", 32'(bus.tx), 1);
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_done", 32'(bus.done), 0);
            return;
          end
        end
        default: ;
      endcase
    end
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_tx", 32'(bus.tx), 1);
    @(negedge clk);
    chk("done_clear", 32'(bus.done), 0);
    busy_hits = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.busy || bus.done || !bus.tx) busy_hits++;
    end
    chk("no_retrigger", 32'(busy_hits), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.end_process = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    set_regs();
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(bus.tx), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic dump
    exp_regs[0] = 12'hABC;
    exp_regs[1] = 12'h123;
    set_regs();
    start_frame();
    run_frame(M_PLAIN);

    // Snapshot ignores later r1 change
    set_regs();
    start_frame();
    run_frame(M_SNAP);

    // Retrigger mid-frame ignored
    rand_regs();
    set_regs();
    start_frame();
    run_frame(M_RETRIG);

    // end_process held high across DONE
    rand_regs();
    set_regs();
    start_frame();
    run_frame(M_HOLD);
    bus.end_process = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-frame, release with end_process high gives a fresh dump
    rand_regs();
    set_regs();
    start_frame();
    run_frame(M_RST);
    rand_regs();
    set_regs();
    @(negedge clk);
    rst = 1'b0;
    run_frame(M_PLAIN);

    // Maximum values
    for (int i = 0; i < 16; i++) exp_regs[i] = 12'hFFF;
    set_regs();
    start_frame();
    run_frame(M_PLAIN);

    // Random frames
    for (int n = 0; n < 3; n++) begin
      rand_regs();
      set_regs();
      start_frame();
      run_frame(M_PLAIN);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
